apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Upstream neighbour of the APB memory slave: converts a simple valid/ready command stream into APB3/APB4 master transfers (IDLE/SETUP/ACCESS).
- Queues commands in a small FIFO, issues one APB transfer at a time, and returns a response (read data plus error) on a valid/ready response channel.
- Drives the slave's PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT and samples PREADY/PRDATA/PSLVERR.

Parameters:
- ADDR_W, 32, width of req_addr and PADDR
- DATA_W, 32, width of write/read data; PSTRB width is DATA_W/8
- DEPTH, 4, command FIFO entries; power of 2, ≥2
- TIMEOUT, 16, PREADY wait limit in ACCESS cycles (used only with APB_TIMEOUT_EN)

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  FIFO not full
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  byte strobes (passed through; reads drive PSTRB=0)
- req_prot  in  3  protection attributes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_slverr  out  1  error flag
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PSTRB  out  DATA_W/8  APB strobes
- PPROT  out  3  APB protection
- PREADY  in  1  APB ready
- PRDATA  in  DATA_W  APB read data
- PSLVERR  in  1  APB error

Behaviour:
- One clock (PCLK); reset is asynchronous and active-low (PRESETn).
- Reset (async assert):
  - FIFO flushed; state IDLE.
  - All APB outputs 0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0.
  - req_ready=0 while PRESETn=0 and 1 from the first edge after deassertion.
- Push: on an edge with req_valid && req_ready, the entry {write,addr,wdata,strb,prot} is written. req_ready=0 when the FIFO is full.
- FSM (all APB outputs registered):
  - IDLE: if FIFO non-empty, pop and load the PADDR/PWRITE/PWDATA/PSTRB/PPROT registers; next state SETUP with PSEL=1, PENABLE=0.
  - SETUP: exactly 1 cycle; next state ACCESS with PENABLE=1. Address, control and data stay stable until the transfer completes.
  - ACCESS: hold while PREADY=0. On an edge with PREADY=1:
    - capture PRDATA (reads only; writes give 0) and PSLVERR;
    - PSEL=PENABLE=0;
    - next state RESP with rsp_valid=1.
  - RESP: rsp_valid, rsp_rdata and rsp_slverr held stable until rsp_ready=1; then rsp_valid=0 and next state IDLE.
- Ordering and outstanding transfers:
  - Exactly one outstanding transfer; responses come back in command order.
  - The FIFO keeps accepting commands during SETUP, ACCESS and RESP.
- Minimum latency, accept to rsp_valid with an empty FIFO, PREADY=1 and rsp_ready=1: 4 edges (push, IDLE pop to SETUP, ACCESS, RESP).
- Back-to-back throughput: 1 transfer per 4 cycles (IDLE cycle between transfers).
- Simultaneous push and pop on the same edge:
  - legal when the FIFO is full (the pop frees the slot, but req_ready is still 0 that cycle, so no push occurs);
  - legal when empty only if the command was already present; a same-cycle push is not bypassed.
- FIFO pointers are DEPTH-wrapping with an extra wrap bit for the full/empty distinction.
- Reset mid-ACCESS: PSEL/PENABLE drop immediately (async); the transfer is abandoned and no response is produced.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments on each PREADY=0 cycle.
  - If it reaches TIMEOUT, the bridge drives PSEL=PENABLE=0 and enters RESP with rsp_slverr=1 and rsp_rdata=0.
  - A PREADY on that same edge wins (normal completion).
- Undefined: no counter; ACCESS waits for PREADY indefinitely.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - the packed command struct apb_cmd_t {write, addr, wdata, strb, prot};
  - default width localparams.
- One natural sub-module: apb_cmd_fifo (synchronous FIFO with async active-low reset; push/pop/full/empty).

Test Plan:
- After reset, push read addr=5 with PREADY tied 1 to the memory slave -> rsp_rdata=0x00000005, rsp_slverr=0; PSEL high for exactly 2 cycles.
- Write addr=0x10 data=0xDEADBEEF strb=0xF, then read addr=0x10 -> second response rsp_rdata=0xDEADBEEF; PWDATA and PADDR stable across SETUP/ACCESS.
- Hold rsp_ready=0 and push 6 commands back-to-back with DEPTH=4 -> 5 accepted (1 in RESP, 4 queued) and req_ready=0 on the 6th. Then release rsp_ready -> 5 in-order responses, after which req_ready=1.
- Slave holds PREADY=0 for 3 ACCESS cycles, then PREADY=1 with PSLVERR=1 -> PENABLE high for 4 cycles and rsp_slverr=1.
- With APB_TIMEOUT_EN, PREADY stuck 0 -> after 16 ACCESS cycles PSEL=0, rsp_valid=1, rsp_slverr=1, and the next queued command proceeds normally.
- Assert PRESETn low during ACCESS with 2 commands queued -> PSEL/PENABLE=0 immediately, no rsp_valid after release, FIFO empty, req_ready=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: transfer-state enum, command record
// and default widths.
package apb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STRB_W = DEF_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        logic [DEF_STRB_W-1:0] strb;
        logic [2:0]            prot;
    } apb_cmd_t;

    // Flat width of one queued command {write, addr, wdata, strb, prot}.
    function automatic int cmd_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8 + 3;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO, power-of-two depth, wrap-bit pointers for the
// full/empty distinction. Writes when full and reads when empty are ignored.
module apb_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [W-1:0]   mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign dout  = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: the storage array has no reset; clearing the pointers empties the
    // FIFO, and stale words are never read before being rewritten.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PTR_W-1:0]] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Command-stream to APB3/APB4 master bridge: queues requests, runs one
// registered IDLE/SETUP/ACCESS transfer at a time, returns in-order responses.
// Optional macro APB_TIMEOUT_EN adds a PREADY watchdog of TIMEOUT ACCESS cycles.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    input  logic [2:0]          req_prot,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_slverr,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    output logic [2:0]          PPROT,
    input  logic                PREADY,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CMD_W  = cmd_width(ADDR_W, DATA_W);

    // Out-of-range DEPTH/TIMEOUT leave this scope in the elaborated hierarchy.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_invalid_params
    end

    apb_state_e state_q, state_d;

    logic              ready_q;
    logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [CMD_W-1:0]  fifo_dout;

    logic              c_write;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [STRB_W-1:0] c_strb;
    logic [2:0]        c_prot;

    logic              psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_slverr_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
    logic [STRB_W-1:0] pstrb_d;
    logic [2:0]        pprot_d;
    logic              xfer_done;

`ifdef APB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`endif

    // ready_q holds req_ready low until the first edge after reset release.
    assign req_ready = ready_q && !fifo_full;
    assign fifo_push = req_valid && req_ready;

    assign {c_write, c_addr, c_wdata, c_strb, c_prot} = fifo_dout;

    apb_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (fifo_push),
        .din   ({req_write, req_addr, req_wdata, req_strb, req_prot}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        psel_d       = PSEL;
        penable_d    = PENABLE;
        pwrite_d     = PWRITE;
        paddr_d      = PADDR;
        pwdata_d     = PWDATA;
        pstrb_d      = PSTRB;
        pprot_d      = PPROT;
        rsp_valid_d  = rsp_valid;
        rsp_rdata_d  = rsp_rdata;
        rsp_slverr_d = rsp_slverr;
        fifo_pop     = 1'b0;
        xfer_done    = 1'b0;
`ifdef APB_TIMEOUT_EN
        tcnt_d       = tcnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    pwrite_d = c_write;
                    paddr_d  = c_addr;
                    pwdata_d = c_wdata;
                    pstrb_d  = c_write ? c_strb : '0;
                    pprot_d  = c_prot;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                tcnt_d    = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    xfer_done    = 1'b1;
                    rsp_rdata_d  = PWRITE ? '0 : PRDATA;
                    rsp_slverr_d = PSLVERR;
                end
`ifdef APB_TIMEOUT_EN
                else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    xfer_done    = 1'b1;
                    rsp_rdata_d  = '0;
                    rsp_slverr_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer_done) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PSTRB      <= '0;
            PPROT      <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ready_q    <= 1'b1;
            PSEL       <= psel_d;
            PENABLE    <= penable_d;
            PWRITE     <= pwrite_d;
            PADDR      <= paddr_d;
            PWDATA     <= pwdata_d;
            PSTRB      <= pstrb_d;
            PPROT      <= pprot_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            rsp_slverr <= rsp_slverr_d;
`ifdef APB_TIMEOUT_EN
            tcnt_q     <= tcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: APB memory slave, transaction-level model of
// expected transfers/responses, per-cycle compare, directed scenarios.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_strb;
    logic [2:0]        req_prot;
    logic              rsp_valid, rsp_ready, rsp_slverr;
    logic [DATA_W-1:0] rsp_rdata;
    logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;
    logic [STRB_W-1:0] PSTRB;
    logic [2:0]        PPROT;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- APB memory slave (mem[i] = i after init) ----------------
    logic [31:0] slv_mem [256];
    logic        slv_init = 1'b0;
    int          acc_cnt = 0;
    int          wait_n = 0;
    logic        err_en = 1'b0;
    logic        stuck_en = 1'b0;   // address 0xFF never gets PREADY

    assign PREADY  = PSEL && PENABLE && (acc_cnt >= wait_n) &&
                     !(stuck_en && PADDR[7:0] == 8'hFF);
    assign PRDATA  = slv_mem[PADDR[7:0]];
    assign PSLVERR = err_en;

    always @(posedge PCLK) begin
        if (!slv_init) begin
            for (int i = 0; i < 256; i++) slv_mem[i] <= i;
            slv_init <= 1'b1;
        end else if (PSEL && PENABLE && PREADY && PWRITE) begin
            for (int b = 0; b < STRB_W; b++)
                if (PSTRB[b]) slv_mem[PADDR[7:0]][8*b +: 8] <= PWDATA[8*b +: 8];
        end
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
    } rsp_t;

    apb_cmd_t    iss_q[$];
    rsp_t        exp_q[$];
    logic [31:0] model_mem [256];
    logic        model_init = 1'b0;

    function automatic void model_push(input apb_cmd_t c);
        rsp_t     r;
        apb_cmd_t e = c;
        if (!c.write) e.strb = '0;
        iss_q.push_back(e);
        if (stuck_en && c.addr[7:0] == 8'hFF) begin
            r.rdata  = '0;
            r.slverr = 1'b1;
        end else begin
            r.slverr = err_en;
            r.rdata  = '0;
            if (c.write) begin
                for (int b = 0; b < STRB_W; b++)
                    if (c.strb[b]) model_mem[c.addr[7:0]][8*b +: 8] = c.wdata[8*b +: 8];
            end else begin
                r.rdata = model_mem[c.addr[7:0]];
            end
        end
        exp_q.push_back(r);
    endfunction

    // ---------------- per-cycle compare (negedge) ----------------
    int          cyc = 0;
    int          push_cyc = 0;
    int          rsp_lat = 0;
    int          rsp_cnt = 0;
    int          psel_cycles = 0;
    int          penable_cycles = 0;
    logic [31:0] last_rdata = '0;
    logic        last_slverr = 1'b0;
    logic        rsp_valid_prev = 1'b0;
    apb_cmd_t    snap;

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        if (!model_init) begin
            for (int i = 0; i < 256; i++) model_mem[i] = i;
            model_init = 1'b1;
        end
        if (!PRESETn) begin
            iss_q.delete();
            exp_q.delete();
            rsp_valid_prev = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                apb_cmd_t c;
                c.write = req_write;
                c.addr  = req_addr;
                c.wdata = req_wdata;
                c.strb  = req_strb;
                c.prot  = req_prot;
                model_push(c);
                push_cyc = cyc;
            end
            if (PSEL) psel_cycles++;
            if (PENABLE) penable_cycles++;
            if (PSEL || PENABLE) check("penable_implies_psel", PSEL, 1'b1);
            if (PSEL && !PENABLE) begin
                if (iss_q.size() == 0) begin
                    check("unexpected_setup", 1'b1, 1'b0);
                end else begin
                    snap = iss_q.pop_front();
                    check("setup_paddr", PADDR, snap.addr);
                    check("setup_pwrite", PWRITE, snap.write);
                    check("setup_pstrb", PSTRB, snap.strb);
                    check("setup_pprot", PPROT, snap.prot);
                    if (snap.write) check("setup_pwdata", PWDATA, snap.wdata);
                end
            end
            if (PSEL && PENABLE) begin
                check("access_paddr_stable", PADDR, snap.addr);
                check("access_pwrite_stable", PWRITE, snap.write);
                check("access_pstrb_stable", PSTRB, snap.strb);
                if (snap.write) check("access_pwdata_stable", PWDATA, snap.wdata);
            end
            if (rsp_valid) begin
                if (!rsp_valid_prev) rsp_lat = cyc - push_cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1'b1, 1'b0);
                end else begin
                    check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                    check("rsp_slverr", rsp_slverr, exp_q[0].slverr);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        last_rdata  = rsp_rdata;
                        last_slverr = rsp_slverr;
                        rsp_cnt++;
                    end
                end
            end
            rsp_valid_prev = rsp_valid;
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic try_push(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] p, output logic acc);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        req_prot  = p;
        @(negedge PCLK);
        acc = req_ready;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p);
        logic acc = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) try_push(w, a, d, s, p, acc);
        if (!acc) check("push_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_rsp(input int target);
        for (int n = 0; n < 300 && rsp_cnt < target; n++) tick();
        if (rsp_cnt < target) check("rsp_wait_timeout", rsp_cnt, target);
    endtask

    initial begin
        logic acc;
        int   n_acc;
        int   base;
        int   sel_seen;

        PRESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        rsp_ready = 1'b1;

        // Reset values.
        #12;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_slverr", rsp_slverr, 1'b0);
        @(negedge PCLK);
        #1 PRESETn = 1'b1;
        #1 check("ready_before_first_edge", req_ready, 1'b0);
        tick();
        check("ready_after_first_edge", req_ready, 1'b1);

        // 1: single read, minimum latency.
        psel_cycles = 0;
        push(1'b0, 32'h5, 32'h0, 4'hF, 3'b000);
        wait_rsp(1);
        check("t1_rdata", last_rdata, 32'h0000_0005);
        check("t1_slverr", last_slverr, 1'b0);
        check("t1_psel_cycles", psel_cycles, 2);
        check("t1_latency_edges", rsp_lat, 4);

        // 2: write then read back; partial strobes.
        push(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010);
        push(1'b0, 32'h10, 32'h0, 4'hF, 3'b001);
        wait_rsp(3);
        check("t2_readback", last_rdata, 32'hDEAD_BEEF);
        push(1'b1, 32'h11, 32'hAABB_CCDD, 4'h5, 3'b000);
        push(1'b0, 32'h11, 32'h0, 4'h0, 3'b000);
        wait_rsp(5);
        check("t2_partial_strb", last_rdata, 32'h00BB_00DD);

        // 3: fill FIFO while response is stalled.
        rsp_ready = 1'b0;
        base  = rsp_cnt;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            try_push(i[0], 32'h20 + i, 32'h1111_0000 + i, 4'hF, 3'(i), acc);
            if (acc) n_acc++;
        end
        check("t3_accepted", n_acc, 5);
        check("t3_sixth_rejected", acc, 1'b0);
        tick();
        tick();
        check("t3_ready_while_full", req_ready, 1'b0);
        check("t3_rsp_held", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        wait_rsp(base + 5);
        tick();
        check("t3_ready_after_drain", req_ready, 1'b1);

        // 4: wait states with error.
        wait_n = 3;
        err_en = 1'b1;
        penable_cycles = 0;
        push(1'b0, 32'h30, 32'h0, 4'h0, 3'b000);
        wait_rsp(rsp_cnt + 1);
        err_en = 1'b0;
        wait_n = 0;
        check("t4_penable_cycles", penable_cycles, 4);
        check("t4_slverr", last_slverr, 1'b1);
        check("t4_rdata", last_rdata, 32'h30);

`ifdef APB_TIMEOUT_EN
        // 5: PREADY stuck low -> watchdog, next command proceeds.
        stuck_en = 1'b1;
        penable_cycles = 0;
        base = rsp_cnt;
        push(1'b0, 32'hFF, 32'h0, 4'h0, 3'b000);
        push(1'b0, 32'h03, 32'h0, 4'h0, 3'b000);
        wait_rsp(base + 1);
        check("t5_penable_cycles", penable_cycles, TIMEOUT);
        check("t5_slverr", last_slverr, 1'b1);
        check("t5_rdata", last_rdata, 32'h0);
        wait_rsp(base + 2);
        check("t5_next_rdata", last_rdata, 32'h3);
        check("t5_next_slverr", last_slverr, 1'b0);
        stuck_en = 1'b0;
`endif

        // 6: reset during ACCESS with two commands queued.
        wait_n = 8;
        push(1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
        push(1'b0, 32'h41, 32'h0, 4'h0, 3'b000);
        push(1'b0, 32'h42, 32'h0, 4'h0, 3'b000);
        for (int n = 0; n < 20 && !PENABLE; n++) tick();
        check("t6_in_access", PENABLE, 1'b1);
        #3 PRESETn = 1'b0;
        #1;
        check("t6_psel_async", PSEL, 1'b0);
        check("t6_penable_async", PENABLE, 1'b0);
        check("t6_ready_in_reset", req_ready, 1'b0);
        @(negedge PCLK);
        #2 PRESETn = 1'b1;
        wait_n = 0;
        base = rsp_cnt;
        sel_seen = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (PSEL || rsp_valid) sel_seen++;
        end
        check("t6_no_activity_after_reset", sel_seen, 0);
        check("t6_no_rsp", rsp_cnt, base);
        check("t6_ready_after_reset", req_ready, 1'b1);
        push(1'b0, 32'h06, 32'h0, 4'h0, 3'b000);
        wait_rsp(base + 1);
        check("t6_post_reset_rdata", last_rdata, 32'h6);

        tick();
        tick();
        check("drained_responses", exp_q.size(), 0);
        check("drained_issues", iss_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
